// File: rtl/qsys0_avm_pio_master.sv
// Avalon-MM single-beat initiator for qsys0 PIO slaves: command/response front end, waitrequest and fixed read latency.
// Optional waitrequest timeout abort is compiled in with AVM_TIMEOUT_EN.
module qsys0_avm_pio_master #(
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {IDLE, WR, RD, LAT, RESP} state_t;

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_t     state;
  logic [2:0] lat_cnt;

`ifdef AVM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;
  logic       rsp_error_q;
  assign rsp_error = rsp_error_q;
`else
  assign rsp_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read_n     <= 1'b1;
      avm_writedata  <= '0;
`ifdef AVM_TIMEOUT_EN
      to_cnt         <= '0;
      rsp_error_q    <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready      <= 1'b0;
            avm_chipselect <= 1'b1;
            avm_address    <= cmd_address;
`ifdef AVM_TIMEOUT_EN
            to_cnt         <= '0;
`endif
            if (cmd_write) begin
              avm_write_n   <= 1'b0;
              avm_writedata <= cmd_wdata;
              state         <= WR;
            end else begin
              avm_read_n <= 1'b0;
              state      <= RD;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR, RD: begin
          if (!avm_waitrequest) begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_read_n     <= 1'b1;
            if (state == WR) begin
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
`ifdef AVM_TIMEOUT_EN
              rsp_error_q <= 1'b0;
`endif
            end else if (READ_LATENCY == 0) begin
              rsp_rdata <= avm_readdata;
              rsp_valid <= 1'b1;
              state     <= RESP;
`ifdef AVM_TIMEOUT_EN
              rsp_error_q <= 1'b0;
`endif
            end else begin
              lat_cnt <= LAT_LAST;
              state   <= LAT;
            end
          end
`ifdef AVM_TIMEOUT_EN
          // Abort lands on the edge that completes the TIMEOUT_CYCLES-th stall cycle
          else if (to_cnt == TO_LAST) begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_read_n     <= 1'b1;
            rsp_rdata      <= '0;
            rsp_error_q    <= 1'b1;
            rsp_valid      <= 1'b1;
            state          <= RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        LAT: begin
          if (lat_cnt == '0) begin
            rsp_rdata <= avm_readdata;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef AVM_TIMEOUT_EN
            rsp_error_q <= 1'b0;
`endif
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
